// File: rtl/food_spawn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : food_spawn_ctrl
// Desc   : Picks a random free playfield cell for the snake's food using a
//          pair of 6-bit LFSRs, checking candidates against the body store.
//          Optional raster fallback scan: define FOOD_FALLBACK_SCAN_EN.
// Rev    : 1.0  initial release
// ============================================================================
module food_spawn_ctrl #(
  parameter int         GRID_W    = 40,
  parameter int         GRID_H    = 30,
  parameter int         MAX_TRIES = 63,
  parameter logic [5:0] SEED_X    = 6'h0F,
  parameter logic [5:0] SEED_Y    = 6'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn_req,
  output logic       busy,
  output logic       occ_req,
  output logic [5:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic       food_valid,
  output logic [5:0] food_x,
  output logic [5:0] food_y,
  output logic       fail
);

  localparam logic [6:0] c_GRID_W    = 7'(GRID_W);
  localparam logic [6:0] c_GRID_H    = 7'(GRID_H);
  localparam logic [7:0] c_MAX_TRIES = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_RANGE   = 3'd2,
    S_QUERY   = 3'd3,
    S_DONE    = 3'd4,
    S_EXHAUST = 3'd5,
    S_SCAN_Q  = 3'd6,
    S_SCAN_N  = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_exhaust_tgt;
  logic [5:0] r_x_lfsr;
  logic [5:0] r_y_lfsr;
  logic [7:0] r_tries;
  logic [5:0] r_occ_x;
  logic [5:0] r_occ_y;
  logic [5:0] r_food_x;
  logic [5:0] r_food_y;
  logic       w_in_range;
  logic       w_tries_max;

  // x^6+x^5+1; the all-zero lockup state is forced back onto the sequence
  function automatic logic [5:0] lfsr_step(input logic [5:0] r);
    return (r == 6'd0) ? 6'h01 : {r[4:0], r[5] ^ r[4]};
  endfunction

`ifdef FOOD_FALLBACK_SCAN_EN
  localparam logic [5:0] c_LAST_X = 6'(GRID_W - 1);
  localparam logic [5:0] c_LAST_Y = 6'(GRID_H - 1);

  logic [5:0] r_scan_x;
  logic [5:0] r_scan_y;
  logic       w_scan_last;

  assign w_scan_last   = (r_scan_x == c_LAST_X) && (r_scan_y == c_LAST_Y);
  assign w_exhaust_tgt = S_SCAN_N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_x <= 6'd0;
      r_scan_y <= 6'd0;
    end else if (r_state == S_RANGE || r_state == S_QUERY) begin
      r_scan_x <= 6'd0;
      r_scan_y <= 6'd0;
    end else if (r_state == S_SCAN_Q && occ_ack && occ_hit) begin
      if (r_scan_x == c_LAST_X) begin
        r_scan_x <= 6'd0;
        r_scan_y <= r_scan_y + 6'd1;
      end else begin
        r_scan_x <= r_scan_x + 6'd1;
      end
    end
  end
`else
  assign w_exhaust_tgt = S_EXHAUST;
`endif

  assign w_in_range  = ({1'b0, r_x_lfsr} < c_GRID_W) && ({1'b0, r_y_lfsr} < c_GRID_H);
  assign w_tries_max = (r_tries == c_MAX_TRIES);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (spawn_req) w_state_nxt = S_STEP;
      S_STEP:    w_state_nxt = S_RANGE;
      S_RANGE: begin
        if (w_in_range)       w_state_nxt = S_QUERY;
        else if (w_tries_max) w_state_nxt = w_exhaust_tgt;
        else                  w_state_nxt = S_STEP;
      end
      S_QUERY: begin
        if (occ_ack) begin
          if (!occ_hit)         w_state_nxt = S_DONE;
          else if (w_tries_max) w_state_nxt = w_exhaust_tgt;
          else                  w_state_nxt = S_STEP;
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      S_EXHAUST: w_state_nxt = S_IDLE;
`ifdef FOOD_FALLBACK_SCAN_EN
      S_SCAN_Q: begin
        if (occ_ack) begin
          if (!occ_hit)         w_state_nxt = S_DONE;
          else if (w_scan_last) w_state_nxt = S_EXHAUST;
          else                  w_state_nxt = S_SCAN_N;
        end
      end
      S_SCAN_N:  w_state_nxt = S_SCAN_Q;
`endif
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_x_lfsr <= SEED_X;
      r_y_lfsr <= SEED_Y;
      r_tries  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      // X free-runs while idle so the request timing seeds the draw
      if (r_state == S_IDLE || r_state == S_STEP) r_x_lfsr <= lfsr_step(r_x_lfsr);
      if (r_state == S_STEP)                      r_y_lfsr <= lfsr_step(r_y_lfsr);
      if (r_state == S_IDLE && spawn_req)         r_tries  <= 8'd0;
      else if (r_state == S_STEP)                 r_tries  <= r_tries + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ_x  <= 6'd0;
      r_occ_y  <= 6'd0;
      r_food_x <= 6'd0;
      r_food_y <= 6'd0;
    end else begin
      if (r_state == S_RANGE) begin
        r_occ_x <= r_x_lfsr;
        r_occ_y <= r_y_lfsr;
      end
`ifdef FOOD_FALLBACK_SCAN_EN
      else if (r_state == S_SCAN_N) begin
        r_occ_x <= r_scan_x;
        r_occ_y <= r_scan_y;
      end
`endif
      // the query registers still hold the winning cell on the ack edge
      if (w_state_nxt == S_DONE) begin
        r_food_x <= r_occ_x;
        r_food_y <= r_occ_y;
      end
    end
  end

  assign busy       = !(r_state inside {S_IDLE, S_DONE, S_EXHAUST});
  assign occ_req    = (r_state == S_QUERY) || (r_state == S_SCAN_Q);
  assign occ_x      = r_occ_x;
  assign occ_y      = r_occ_y;
  assign food_valid = (r_state == S_DONE);
  assign fail       = (r_state == S_EXHAUST);
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;

endmodule
`default_nettype wire

// File: tb/tb_food_spawn_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_food_spawn_ctrl
// Desc   : Directed and randomized spawns against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_food_spawn_ctrl;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spawn_req = 1'b0;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic       busy, occ_req, food_valid, fail;
  logic [5:0] occ_x, occ_y, food_x, food_y;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;
  int mx, my, fx, fy;
  bit aborted;

  always #5 clk = ~clk;

  food_spawn_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT), .SEED_X(6'h0F), .SEED_Y(6'h2A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .busy(busy),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack),
    .occ_hit(occ_hit), .food_valid(food_valid), .food_x(food_x),
    .food_y(food_y), .fail(fail)
  );

  // shift left, feedback = bit5 xor bit4; zero recovers to 1
  function automatic int lstep(input int r);
    if (r == 0) return 1;
    return ((r * 2) % 64) | (((r >> 5) ^ (r >> 4)) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; spawn_req = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    mx = 15; my = 42; fx = 0; fy = 0;
    aborted = 1'b1;
  endtask

  // ev: 1 query, 2 food_valid, 3 fail, 0 none within budget; n = ticks waited
  task automatic wait_event(output int ev, output int n);
    ev = 0;
    n  = 0;
    for (int k = 0; k < 200; k++) begin
      n = k;
      if (occ_req)         begin ev = 1; break; end
      else if (food_valid) begin ev = 2; break; end
      else if (fail)       begin ev = 3; break; end
      tick();
    end
  endtask

  task automatic check_food_pulse();
    chk("food_valid", food_valid, 1);
    chk("no_fail_with_food", fail, 0);
    chk("busy_in_done", busy, 0);
    chk("food_xy", {food_x, food_y}, {6'(fx), 6'(fy)});
  endtask

  task automatic check_fail_pulse();
    chk("fail_pulse", fail, 1);
    chk("no_food_with_fail", food_valid, 0);
    chk("busy_in_fail", busy, 0);
    chk("food_held", {food_x, food_y}, {6'(fx), 6'(fy)});
  endtask

  // entered with the random attempts used up and the DUT's exhaustion visible
  task automatic exhaust();
`ifdef FOOD_FALLBACK_SCAN_EN
    int ev, n, free_i;
    free_i = $urandom_range(0, 60);
    if (free_i == 60) free_i = GW * GH;
    for (int c = 0; c < GW * GH; c++) begin
      wait_event(ev, n);
      chk("scan_event", ev, 1);
      if (ev != 1) begin reset_dut(); return; end
      chk("scan_xy", {occ_x, occ_y}, {6'(c % GW), 6'(c / GW)});
      occ_ack = 1'b1; occ_hit = (c != free_i);
      tick();
      occ_ack = 1'b0; occ_hit = 1'b0;
      if (c == free_i) begin
        fx = c % GW; fy = c / GW;
        check_food_pulse();
        return;
      end
    end
    wait_event(ev, n);
    chk("scan_fail_event", ev, 3);
    check_fail_pulse();
`else
    check_fail_pulse();
`endif
  endtask

  task automatic do_spawn(input int idle_n, input int hit_pct, input int min_dly, input int max_dly);
    int ev, n, rej, dly;
    bit hit, done;
    aborted = 1'b0;
    for (int i = 0; i < idle_n; i++) begin
      chk("idle_busy", busy, 0);
      spawn_req = 1'b0;
      tick();
      mx = lstep(mx);
    end
    spawn_req = 1'b1;
    tick();
    mx = lstep(mx);
    spawn_req = 1'b0;
    chk("busy_rise", busy, 1);
    rej = 0;
    done = 1'b0;
    for (int t = 1; t <= MT && !done; t++) begin
      mx = lstep(mx);
      my = lstep(my);
      if (mx < GW && my < GH) begin
        wait_event(ev, n);
        chk("query_event", ev, 1);
        chk("query_latency", n, 2 * (rej + 1));
        if (ev != 1) begin reset_dut(); return; end
        rej = 0;
        chk("occ_xy", {occ_x, occ_y}, {6'(mx), 6'(my)});
        dly = $urandom_range(min_dly, max_dly);
        hit = ($urandom_range(0, 99) < hit_pct);
        for (int d = 0; d < dly; d++) begin
          spawn_req = (d % 2 == 0);
          tick();
          spawn_req = 1'b0;
          chk("hold_req", occ_req, 1);
          chk("hold_xy", {occ_x, occ_y}, {6'(mx), 6'(my)});
        end
        occ_ack = 1'b1; occ_hit = hit;
        tick();
        occ_ack = 1'b0; occ_hit = 1'b0;
        chk("req_drop", occ_req, 0);
        if (!hit) begin
          fx = mx; fy = my;
          check_food_pulse();
          done = 1'b1;
        end else if (t == MT) begin
          exhaust();
          done = 1'b1;
        end
      end else begin
        rej++;
        if (t == MT) begin
`ifndef FOOD_FALLBACK_SCAN_EN
          wait_event(ev, n);
          chk("fail_event", ev, 3);
          chk("fail_latency", n, 2 * rej);
          if (ev != 3) begin reset_dut(); return; end
`endif
          exhaust();
          done = 1'b1;
        end
      end
      if (aborted) return;
    end
    tick();
    chk("pulse_end", {food_valid, fail}, 0);
  endtask

  initial begin
    reset_dut();
    chk("rst_busy", busy, 0);
    chk("rst_occ_req", occ_req, 0);
    chk("rst_occ_xy", {occ_x, occ_y}, 0);
    chk("rst_food_xy", {food_x, food_y}, 0);
    chk("rst_pulses", {food_valid, fail}, 0);

    // 4 idle cycles: candidate (17,21), queried 3 cycles after the request
    do_spawn(4, 0, 0, 0);
    chk("dir_food_a", {food_x, food_y}, {6'd17, 6'd21});

    // x == GRID_W (40) is rejected; third candidate (35,23) wins
    reset_dut();
    do_spawn(3, 0, 0, 0);
    chk("dir_food_edge", {food_x, food_y}, {6'd35, 6'd23});

    // every draw out of range: fail after MAX_TRIES, food stays at reset value
    reset_dut();
    do_spawn(0, 100, 0, 0);
    chk("dir_exhaust_food", {food_x, food_y}, 0);
    chk("dir_exhaust_busy", busy, 0);

    // slow ack with spawn_req pulsed while waiting
    reset_dut();
    do_spawn(4, 0, 5, 5);
    chk("dir_slow_food", {food_x, food_y}, {6'd17, 6'd21});
    do_spawn(2, 0, 0, 2);

    // asynchronous reset in the middle of a query
    reset_dut();
    repeat (4) tick();
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    repeat (2) tick();
    chk("pre_rst_req", occ_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", occ_req, 0);
    chk("async_rst_busy", busy, 0);
    reset_dut();
    do_spawn(4, 0, 0, 0);
    chk("post_rst_food", {food_x, food_y}, {6'd17, 6'd21});

    for (int r = 0; r < 40; r++) begin
      do_spawn($urandom_range(0, 6), $urandom_range(0, 100), 0, 3);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
